floor_request_scheduler: RTL and testbench

//  Upstream stage of the external-hardware interface: latches floor requests (cab + hall buttons),

---
 rtl/floor_request_scheduler_if.sv | 42 ++++
 rtl/floor_request_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_floor_request_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/floor_request_scheduler_if.sv
// ----------------------------------------------------------------------------
// floor_request_scheduler_if
//   Bundles the car-side signals of the floor request scheduler.
//
//   Signal summary
//     req_buttons   car/hall -> sched  level request per floor (OR of cab+hall)
//     current_floor car HW   -> sched  car position
//     car_stopped   car HW   -> sched  1 = car stationary at current_floor
//     target_word   sched    -> sw     {4'b0, door_open, target_valid, target[1:0]}
//     pending       sched    -> sw     latched outstanding requests
//     dir_up        sched    -> sw     current sweep direction (1 = up)
//     door_open     sched    -> car    door open command
//     dbg_state     sched    -> debug  FSM state (0 IDLE, 1 SERVE, 2 DOOR_OPEN)
//
//   Transfer semantics: there is no valid/ready handshake on this bus. All
//   inputs are levels sampled on every rising clk edge. All outputs are
//   registered levels. target_floor is only meaningful while target_valid
//   (target_word[2]) is 1, and there is no back-pressure on any signal.
// ----------------------------------------------------------------------------
interface floor_request_scheduler_if #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
);
  logic [NUM_FLOORS-1:0] req_buttons;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  car_stopped;
  logic [7:0]            target_word;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  door_open;
  logic [1:0]            dbg_state;

  modport master (
    output req_buttons, current_floor, car_stopped,
    input  target_word, pending, dir_up, door_open, dbg_state
  );

  modport slave (
    input  req_buttons, current_floor, car_stopped,
    output target_word, pending, dir_up, door_open, dbg_state
  );
endinterface

// File: rtl/floor_request_scheduler.sv
// ----------------------------------------------------------------------------
// floor_request_scheduler
//   Latches floor requests, selects the next target floor with a SCAN
//   (keep-direction) policy and times the door dwell at each stop.
//
//   Ports
//     clk    in  system clock, rising edge
//     reset  in  synchronous, active-high reset
//     bus    floor_request_scheduler_if.slave (requests, car position,
//            target word, pending mask, direction, door command, debug state)
// ----------------------------------------------------------------------------
module floor_request_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int FLOOR_W     = 2,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  floor_request_scheduler_if.slave        bus
);

  localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SERVE     = 2'd1,
    ST_DOOR_OPEN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic                  target_valid_q, target_valid_d;
  logic                  dir_up_q, dir_up_d;
  logic                  door_open_q, door_open_d;
  logic [CNT_W-1:0]      door_cnt_q, door_cnt_d;

  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] req_mask;
  logic                  cur_hit;
  logic                  arrive;
  logic                  above_found, below_found;
  logic [FLOOR_W-1:0]    above_f, below_f;
  logic                  pick_found, pick_dir;
  logic [FLOOR_W-1:0]    pick_f;
  logic [1:0]            target_lo;

  // One-hot of the car position. An out-of-range position yields all zeros,
  // so it can never match, stop or clear anything.
  always_comb begin
    cur_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      cur_mask[i] = (int'(bus.current_floor) == i);
    end
  end

  assign cur_hit = |(pending_q & cur_mask);
  assign arrive  = bus.car_stopped && (target_q == bus.current_floor);

  // Nearest pending floor above and below the car. The floor the car is at
  // is excluded from both, so a request there waits for a stop.
  always_comb begin
    above_found = 1'b0;
    above_f     = '0;
    below_found = 1'b0;
    below_f     = '0;
    // Descending scan: the last hit is the lowest floor above the car.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending_q[i] && (i > int'(bus.current_floor))) begin
        above_found = 1'b1;
        above_f     = FLOOR_W'(i);
      end
    end
    // Ascending scan: the last hit is the highest floor below the car.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending_q[i] && (i < int'(bus.current_floor))) begin
        below_found = 1'b1;
        below_f     = FLOOR_W'(i);
      end
    end
  end

  // SCAN choice: keep the sweep direction while anything is pending ahead,
  // reverse only when the current direction has run out of requests.
  always_comb begin
    pick_found = 1'b0;
    pick_f     = target_q;
    pick_dir   = dir_up_q;
    if (dir_up_q) begin
      if (above_found) begin
        pick_found = 1'b1;
        pick_f     = above_f;
      end else if (below_found) begin
        pick_found = 1'b1;
        pick_f     = below_f;
        pick_dir   = 1'b0;
      end
    end else begin
      if (below_found) begin
        pick_found = 1'b1;
        pick_f     = below_f;
      end else if (above_found) begin
        pick_found = 1'b1;
        pick_f     = above_f;
        pick_dir   = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    target_d       = target_q;
    target_valid_d = target_valid_q;
    dir_up_d       = dir_up_q;
    door_open_d    = door_open_q;
    door_cnt_d     = door_cnt_q;
    clr_mask       = '0;
    req_mask       = '1;

    case (state_q)
      ST_IDLE: begin
        target_valid_d = 1'b0;
        door_open_d    = 1'b0;
        if (cur_hit && bus.car_stopped) begin
          state_d     = ST_DOOR_OPEN;
          clr_mask    = cur_mask;
          door_open_d = 1'b1;
          door_cnt_d  = CNT_RELOAD;
        end else if (pick_found) begin
          state_d        = ST_SERVE;
          target_d       = pick_f;
          target_valid_d = 1'b1;
          dir_up_d       = pick_dir;
        end
      end

      ST_SERVE: begin
        // Arrival takes priority over retargeting: once the car stops at
        // the target, that stop is served even if others are pending.
        if (arrive) begin
          state_d        = ST_DOOR_OPEN;
          clr_mask       = cur_mask;
          target_valid_d = 1'b0;
          door_open_d    = 1'b1;
          door_cnt_d     = CNT_RELOAD;
        end else if (pick_found) begin
          target_d = pick_f;
          dir_up_d = pick_dir;
        end
      end

      ST_DOOR_OPEN: begin
        // A press for the open floor extends the dwell instead of queueing.
        req_mask = ~cur_mask;
        if (|(bus.req_buttons & cur_mask)) begin
          door_cnt_d = CNT_RELOAD;
        end else if (door_cnt_q == '0) begin
          state_d     = ST_IDLE;
          door_open_d = 1'b0;
        end else begin
          door_cnt_d = door_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Clear is applied after the OR so a stop beats a simultaneous press.
    pending_d = (pending_q | (bus.req_buttons & req_mask)) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      target_q       <= '0;
      target_valid_q <= 1'b0;
      dir_up_q       <= 1'b1;
      door_open_q    <= 1'b0;
      door_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      dir_up_q       <= dir_up_d;
      door_open_q    <= door_open_d;
      door_cnt_q     <= door_cnt_d;
    end
  end

  assign target_lo       = 2'(target_q);
  assign bus.target_word = {4'b0000, door_open_q, target_valid_q, target_lo};
  assign bus.pending     = pending_q;
  assign bus.dir_up      = dir_up_q;
  assign bus.door_open   = door_open_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// ----------------------------------------------------------------------------
// tb_floor_request_scheduler
//   Directed scenarios (reset, basic trip, retarget, reversal, door extend,
//   simultaneous arrival/press) plus random back-to-back single-floor trips.
//   Every stop the bench expects is queued in exp_q when the request is made;
//   a monitor pops it on each door-open rising edge and compares the floor.
// ----------------------------------------------------------------------------
module tb_floor_request_scheduler;
  localparam int NUM_FLOORS  = 4;
  localparam int FLOOR_W     = 2;
  localparam int DOOR_CYCLES = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [FLOOR_W-1:0] exp_q[$];
  logic               door_prev = 1'b0;

  floor_request_scheduler_if #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) bus ();

  floor_request_scheduler #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W),
    .DOOR_CYCLES(DOOR_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stop-order scoreboard ----------------
  always @(negedge clk) begin
    logic [FLOOR_W-1:0] exp_f;
    if (reset === 1'b1) begin
      door_prev = 1'b0;
    end else begin
      if (bus.door_open === 1'b1 && door_prev !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stop_order: got stop at floor %0d expected no stop", bus.current_floor);
        end else begin
          exp_f = exp_q.pop_front();
          if (bus.current_floor !== exp_f) begin
            errors++;
            $display("FAIL stop_order: got stop at floor %0d expected floor %0d",
                     bus.current_floor, exp_f);
          end
        end
      end
      door_prev = bus.door_open;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts door-open cycles starting from the current one, bounded.
  task automatic run_door(output int n);
    n = 0;
    while (bus.door_open === 1'b1 && n < 40) begin
      n++;
      tick();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.req_buttons   = '0;
    bus.current_floor = 2'd0;
    bus.car_stopped   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (bus.target_word !== 8'h00) begin errors++; $display("FAIL reset_target_word: got %h expected 00", bus.target_word); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", bus.pending); end
    checks++; if (bus.dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir_up: got %b expected 1", bus.dir_up); end
    checks++; if (bus.door_open !== 1'b0) begin errors++; $display("FAIL reset_door: got %b expected 0", bus.door_open); end
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, S_IDLE); end

    bus.req_buttons = 4'b1010;
    tick();
    bus.req_buttons = '0;
    checks++; if (bus.pending !== 4'b1010) begin errors++; $display("FAIL reset_pre_pending: got %b expected 1010", bus.pending); end
    checks++; if (bus.target_word !== 8'h00) begin errors++; $display("FAIL reset_pre_latency: got %h expected 00", bus.target_word); end
    tick();
    checks++; if (bus.target_word !== 8'h05) begin errors++; $display("FAIL reset_pre_target: got %h expected 05", bus.target_word); end
    checks++; if (bus.dbg_state !== S_SERVE) begin errors++; $display("FAIL reset_pre_state: got %0d expected %0d", bus.dbg_state, S_SERVE); end

    // Reset in SERVE with a request held during reset: both are dropped.
    bus.car_stopped = 1'b0;
    reset = 1'b1;
    bus.req_buttons = 4'b0100;
    tick();
    reset = 1'b0;
    bus.req_buttons = '0;
    checks++; if (bus.target_word !== 8'h00) begin errors++; $display("FAIL reset_serve_word: got %h expected 00", bus.target_word); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL reset_serve_pending: got %b expected 0000", bus.pending); end
    checks++; if (bus.dir_up !== 1'b1) begin errors++; $display("FAIL reset_serve_dir: got %b expected 1", bus.dir_up); end
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_serve_state: got %0d expected %0d", bus.dbg_state, S_IDLE); end
    tick();
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL reset_drop_req: got %b expected 0000", bus.pending); end
  endtask

  task automatic test_basic_trip();
    int n;
    bus.current_floor = 2'd0;
    bus.car_stopped   = 1'b1;
    bus.req_buttons   = 4'b0100;
    tick();
    bus.req_buttons = '0;
    checks++; if (bus.pending !== 4'b0100) begin errors++; $display("FAIL basic_pending: got %b expected 0100", bus.pending); end
    checks++; if (bus.target_word !== 8'h00) begin errors++; $display("FAIL basic_latency: got %h expected 00", bus.target_word); end
    tick();
    checks++; if (bus.target_word !== 8'h06) begin errors++; $display("FAIL basic_target: got %h expected 06", bus.target_word); end
    exp_q.push_back(2'd2);
    bus.car_stopped   = 1'b0;
    bus.current_floor = 2'd1;
    tick();
    checks++; if (bus.target_word !== 8'h06) begin errors++; $display("FAIL basic_moving: got %h expected 06", bus.target_word); end
    bus.current_floor = 2'd2;
    bus.car_stopped   = 1'b1;
    tick();
    checks++; if (bus.door_open !== 1'b1) begin errors++; $display("FAIL basic_door: got %b expected 1", bus.door_open); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL basic_clear: got %b expected 0000", bus.pending); end
    checks++; if (bus.target_word !== 8'h0A) begin errors++; $display("FAIL basic_door_word: got %h expected 0a", bus.target_word); end
    run_door(n);
    checks++; if (n !== DOOR_CYCLES) begin errors++; $display("FAIL basic_dwell: got %0d cycles expected %0d", n, DOOR_CYCLES); end
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL basic_idle: got %0d expected %0d", bus.dbg_state, S_IDLE); end
  endtask

  task automatic test_retarget();
    int n;
    bus.current_floor = 2'd0;
    bus.car_stopped   = 1'b1;
    bus.req_buttons   = 4'b1000;
    tick();
    bus.req_buttons = '0;
    tick();
    checks++; if (bus.target_word !== 8'h07) begin errors++; $display("FAIL retarget_first: got %h expected 07", bus.target_word); end
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    bus.car_stopped = 1'b0;
    bus.req_buttons = 4'b0010;
    tick();
    bus.req_buttons = '0;
    tick();
    checks++; if (bus.target_word !== 8'h05) begin errors++; $display("FAIL retarget_nearer: got %h expected 05", bus.target_word); end
    bus.current_floor = 2'd1;
    bus.car_stopped   = 1'b1;
    tick();
    checks++; if (bus.door_open !== 1'b1) begin errors++; $display("FAIL retarget_door: got %b expected 1", bus.door_open); end
    checks++; if (bus.pending !== 4'b1000) begin errors++; $display("FAIL retarget_clear: got %b expected 1000", bus.pending); end
    run_door(n);
    checks++; if (n !== DOOR_CYCLES) begin errors++; $display("FAIL retarget_dwell: got %0d cycles expected %0d", n, DOOR_CYCLES); end
    tick();
    checks++; if (bus.target_word !== 8'h07) begin errors++; $display("FAIL retarget_resume: got %h expected 07", bus.target_word); end
    bus.car_stopped   = 1'b0;
    bus.current_floor = 2'd2;
    tick();
    bus.current_floor = 2'd3;
    bus.car_stopped   = 1'b1;
    tick();
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL retarget_final_clear: got %b expected 0000", bus.pending); end
    run_door(n);
  endtask

  task automatic test_reversal();
    int n;
    bus.current_floor = 2'd2;
    bus.car_stopped   = 1'b1;
    bus.req_buttons   = 4'b1001;
    tick();
    bus.req_buttons = '0;
    tick();
    checks++; if (bus.target_word !== 8'h07) begin errors++; $display("FAIL reversal_first: got %h expected 07", bus.target_word); end
    checks++; if (bus.dir_up !== 1'b1) begin errors++; $display("FAIL reversal_dir_up: got %b expected 1", bus.dir_up); end
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    bus.car_stopped = 1'b0;
    tick();
    bus.current_floor = 2'd3;
    bus.car_stopped   = 1'b1;
    tick();
    checks++; if (bus.pending !== 4'b0001) begin errors++; $display("FAIL reversal_clear: got %b expected 0001", bus.pending); end
    run_door(n);
    checks++; if (n !== DOOR_CYCLES) begin errors++; $display("FAIL reversal_dwell: got %0d cycles expected %0d", n, DOOR_CYCLES); end
    tick();
    checks++; if (bus.target_word !== 8'h04) begin errors++; $display("FAIL reversal_target: got %h expected 04", bus.target_word); end
    checks++; if (bus.dir_up !== 1'b0) begin errors++; $display("FAIL reversal_dir_down: got %b expected 0", bus.dir_up); end
    bus.car_stopped   = 1'b0;
    bus.current_floor = 2'd2;
    tick();
    bus.current_floor = 2'd1;
    tick();
    bus.current_floor = 2'd0;
    bus.car_stopped   = 1'b1;
    tick();
    checks++; if (bus.door_open !== 1'b1) begin errors++; $display("FAIL reversal_door: got %b expected 1", bus.door_open); end
    run_door(n);
  endtask

  task automatic test_door_extend();
    int n;
    bus.current_floor = 2'd0;
    bus.car_stopped   = 1'b1;
    bus.req_buttons   = 4'b0010;
    tick();
    bus.req_buttons = '0;
    tick();
    checks++; if (bus.target_word !== 8'h05) begin errors++; $display("FAIL extend_target: got %h expected 05", bus.target_word); end
    checks++; if (bus.dir_up !== 1'b1) begin errors++; $display("FAIL extend_dir: got %b expected 1", bus.dir_up); end
    exp_q.push_back(2'd1);
    bus.car_stopped = 1'b0;
    tick();
    bus.current_floor = 2'd1;
    bus.car_stopped   = 1'b1;
    tick();
    // Door cycle 6 is the one where the dwell counter reads 2.
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.door_open !== 1'b1) break;
      n++;
      bus.req_buttons = (n == 6) ? 4'b0010 : 4'b0000;
      tick();
    end
    bus.req_buttons = '0;
    checks++; if (n !== 6 + DOOR_CYCLES) begin errors++; $display("FAIL extend_dwell: got %0d cycles expected %0d", n, 6 + DOOR_CYCLES); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL extend_no_latch: got %b expected 0000", bus.pending); end
  endtask

  task automatic test_simultaneous();
    int n;
    bus.current_floor = 2'd1;
    bus.car_stopped   = 1'b1;
    bus.req_buttons   = 4'b0100;
    tick();
    bus.req_buttons = '0;
    tick();
    checks++; if (bus.target_word !== 8'h06) begin errors++; $display("FAIL simul_target: got %h expected 06", bus.target_word); end
    exp_q.push_back(2'd2);
    bus.car_stopped = 1'b0;
    tick();
    bus.current_floor = 2'd2;
    bus.car_stopped   = 1'b1;
    bus.req_buttons   = 4'b0100;
    tick();
    bus.req_buttons = '0;
    checks++; if (bus.door_open !== 1'b1) begin errors++; $display("FAIL simul_door: got %b expected 1", bus.door_open); end
    checks++; if (bus.pending !== 4'b0000) begin errors++; $display("FAIL simul_clear: got %b expected 0000", bus.pending); end
    run_door(n);
    checks++; if (n !== DOOR_CYCLES) begin errors++; $display("FAIL simul_dwell: got %0d cycles expected %0d", n, DOOR_CYCLES); end
    tick();
    tick();
    checks++; if (bus.dbg_state !== S_IDLE) begin errors++; $display("FAIL simul_idle: got %0d expected %0d", bus.dbg_state, S_IDLE); end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [1:0] cur;
    logic [1:0] f;
    logic [7:0] exp_tw;
    cur = bus.current_floor;
    for (int t = 0; t < 6; t++) begin
      f = 2'($urandom_range(0, NUM_FLOORS - 1));
      if (f == cur) f = cur + 2'd1;
      exp_tw = {4'b0000, 1'b0, 1'b1, f};
      bus.current_floor = cur;
      bus.car_stopped   = 1'b1;
      bus.req_buttons   = '0;
      bus.req_buttons[f] = 1'b1;
      tick();
      bus.req_buttons = '0;
      tick();
      checks++; if (bus.target_word !== exp_tw) begin errors++; $display("FAIL b2b_target: got %h expected %h", bus.target_word, exp_tw); end
      exp_q.push_back(f);
      bus.car_stopped = 1'b0;
      tick();
      bus.current_floor = f;
      bus.car_stopped   = 1'b1;
      tick();
      checks++; if (bus.door_open !== 1'b1) begin errors++; $display("FAIL b2b_door: got %b expected 1", bus.door_open); end
      run_door(n);
      checks++; if (n !== DOOR_CYCLES) begin errors++; $display("FAIL b2b_dwell: got %0d cycles expected %0d", n, DOOR_CYCLES); end
      cur = f;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    bus.req_buttons   = '0;
    bus.current_floor = '0;
    bus.car_stopped   = 1'b1;
    test_reset();
    test_basic_trip();
    test_retarget();
    test_reversal();
    test_door_extend();
    test_simultaneous();
    test_back_to_back();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stop_queue_empty: got %0d stops outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
